// File: rtl/paicore_transfer_sched.sv
// Transfer scheduler: one TX phase, a bus-turnaround guard, then an RX phase
// with optional timeout. Abort and reset can end a transaction at any point.
module paicore_transfer_sched #(
  parameter int All_Channel = 4,
  parameter int TURN_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [31:0]            cfg_send_len,
  input  logic [31:0]            cfg_oframe_max,
  input  logic [31:0]            cfg_rx_timeout,
  input  logic                   cfg_skip_rx,
  input  logic                   tx_done,
  input  logic                   rx_done,
  output logic [All_Channel-1:0] oen,
  output logic [31:0]            send_len,
  output logic [31:0]            oFrameNumMax,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout,
  output logic                   aborted,
  output logic [2:0]             state,
  output logic [31:0]            tx_cycles,
  output logic [31:0]            rx_cycles
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TX   = 3'd1,
    ST_TURN = 3'd2,
    ST_RX   = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [7:0] TURN_LAST = 8'(TURN_CYCLES - 1);

  state_t                 state_r, state_next_s;
  logic [All_Channel-1:0] oen_r;
  logic [31:0]            send_len_r, oframe_max_r, rx_timeout_r;
  logic [31:0]            tx_cycles_r, rx_cycles_r, rx_cycles_inc_s;
  logic                   skip_rx_r, busy_r, done_r, timeout_r, aborted_r;
  logic                   timeout_hit_s;
  logic [7:0]             turn_cnt_r;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Next-state decode; abort outranks every completion input.
  always_comb begin
    state_next_s    = state_r;
    timeout_hit_s   = 1'b0;
    rx_cycles_inc_s = sat_inc(rx_cycles_r);
    case (state_r)
      ST_IDLE: begin
        if (start) state_next_s = ST_TX;
        else       state_next_s = ST_IDLE;
      end
      ST_TX: begin
        if (abort)        state_next_s = ST_IDLE;
        else if (tx_done) state_next_s = skip_rx_r ? ST_DONE : ST_TURN;
        else              state_next_s = ST_TX;
      end
      ST_TURN: begin
        if (abort)                        state_next_s = ST_IDLE;
        else if (turn_cnt_r == TURN_LAST) state_next_s = ST_RX;
        else                              state_next_s = ST_TURN;
      end
      ST_RX: begin
        if (abort) begin
          state_next_s = ST_IDLE;
        end else if (rx_done) begin
          state_next_s = ST_DONE;
        end else if ((rx_timeout_r != 32'd0) && (rx_cycles_inc_s == rx_timeout_r)) begin
          state_next_s  = ST_DONE;
          timeout_hit_s = 1'b1;
        end else begin
          state_next_s = ST_RX;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, registered outputs, configuration latch and cycle counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      oen_r        <= {All_Channel{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      timeout_r    <= 1'b0;
      aborted_r    <= 1'b0;
      send_len_r   <= 32'd0;
      oframe_max_r <= 32'd0;
      rx_timeout_r <= 32'd0;
      skip_rx_r    <= 1'b0;
      tx_cycles_r  <= 32'd0;
      rx_cycles_r  <= 32'd0;
      turn_cnt_r   <= 8'd0;
    end else begin
      state_r <= state_next_s;
      oen_r   <= (state_next_s == ST_TX) ? {All_Channel{1'b1}} : {All_Channel{1'b0}};
      busy_r  <= (state_next_s != ST_IDLE);
      done_r  <= (state_next_s == ST_DONE);
      if ((state_r == ST_IDLE) && start) begin
        send_len_r   <= cfg_send_len;
        oframe_max_r <= cfg_oframe_max;
        rx_timeout_r <= cfg_rx_timeout;
        skip_rx_r    <= cfg_skip_rx;
        timeout_r    <= 1'b0;
        aborted_r    <= 1'b0;
        tx_cycles_r  <= 32'd0;
        rx_cycles_r  <= 32'd0;
      end
      if (state_r == ST_TX) tx_cycles_r <= sat_inc(tx_cycles_r);
      if (state_r == ST_RX) rx_cycles_r <= rx_cycles_inc_s;
      // Turnaround counter restarts whenever TURN is not the current state.
      if (state_r == ST_TURN) turn_cnt_r <= turn_cnt_r + 8'd1;
      else                    turn_cnt_r <= 8'd0;
      if (timeout_hit_s) timeout_r <= 1'b1;
      if ((state_r != ST_IDLE) && abort) aborted_r <= 1'b1;
    end
  end

  assign state        = state_r;
  assign oen          = oen_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign timeout      = timeout_r;
  assign aborted      = aborted_r;
  assign send_len     = send_len_r;
  assign oFrameNumMax = oframe_max_r;
  assign tx_cycles    = tx_cycles_r;
  assign rx_cycles    = rx_cycles_r;

endmodule

// File: tb/tb_paicore_transfer_sched.sv
// Bench for paicore_transfer_sched: table of transactions with hand-derived
// results checked through a scoreboard queue, plus reset/abort/start corner cases.
module tb_paicore_transfer_sched;

  localparam int NCH = 4;

  logic            clk = 1'b0;
  logic            rst, start, abort, cfg_skip_rx, tx_done, rx_done;
  logic [31:0]     cfg_send_len, cfg_oframe_max, cfg_rx_timeout;
  logic [NCH-1:0]  oen;
  logic [31:0]     send_len, oFrameNumMax, tx_cycles, rx_cycles;
  logic            busy, done, timeout, aborted;
  logic [2:0]      state;

  int checks = 0;
  int errors = 0;

  paicore_transfer_sched #(.All_Channel(NCH), .TURN_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_send_len(cfg_send_len), .cfg_oframe_max(cfg_oframe_max),
    .cfg_rx_timeout(cfg_rx_timeout), .cfg_skip_rx(cfg_skip_rx),
    .tx_done(tx_done), .rx_done(rx_done), .oen(oen), .send_len(send_len),
    .oFrameNumMax(oFrameNumMax), .busy(busy), .done(done), .timeout(timeout),
    .aborted(aborted), .state(state), .tx_cycles(tx_cycles), .rx_cycles(rx_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    // inputs
    logic [31:0] len;
    logic [31:0] ofm;
    logic [31:0] to;
    logic        skip;
    int          tx_at;     // TX cycle index carrying tx_done
    int          rx_at;     // RX cycle index carrying rx_done (0 = never)
    int          abort_at;  // RX cycle index carrying abort (0 = never)
    logic        start2;    // extra start pulse on TX cycle 2
    // expected
    int          e_tx;
    int          e_rx;
    int          e_turn;
    int          e_done;
    logic        e_to;
    logic        e_ab;
  } vec_t;

  typedef struct {
    int          tx, rx, turn, dn;
    logic        to, ab;
    logic [31:0] len, ofm;
  } exp_t;

  vec_t vecs[6];
  exp_t sb_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; abort = 1'b0; tx_done = 1'b0; rx_done = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    int tx_k, rx_k, turn_k, dn_k, shape_err, cyc;
    e.tx = v.e_tx; e.rx = v.e_rx; e.turn = v.e_turn; e.dn = v.e_done;
    e.to = v.e_to; e.ab = v.e_ab; e.len = v.len; e.ofm = v.ofm;
    sb_q.push_back(e);
    cfg_send_len = v.len; cfg_oframe_max = v.ofm;
    cfg_rx_timeout = v.to; cfg_skip_rx = v.skip;
    start = 1'b1;
    tick();
    // Scramble cfg to prove the values were latched on the start cycle.
    start = 1'b0;
    cfg_send_len = 32'hDEAD_BEEF; cfg_oframe_max = 32'h1234_5678;
    cfg_rx_timeout = 32'd1; cfg_skip_rx = ~v.skip;
    tx_k = 0; rx_k = 0; turn_k = 0; dn_k = 0; shape_err = 0; cyc = 0;
    while (state != 3'd0 && cyc < 300) begin
      idle_inputs();
      if (oen !== ((state == 3'd1) ? {NCH{1'b1}} : {NCH{1'b0}})) shape_err++;
      if (busy !== 1'b1) shape_err++;
      if (done) dn_k++;
      case (state)
        3'd1: begin
          tx_k++;
          tx_done = (tx_k == v.tx_at);
          start   = v.start2 && (tx_k == 2);
        end
        3'd2: turn_k++;
        3'd3: begin
          rx_k++;
          rx_done = (rx_k == v.rx_at);
          abort   = (rx_k == v.abort_at);
        end
        default: ;
      endcase
      tick();
      cyc++;
    end
    idle_inputs();
    if (cyc >= 300) chk($sformatf("v%0d_bound", idx), 64'(cyc), 64'd0);
    e = sb_q.pop_front();
    chk($sformatf("v%0d_tx_cycles", idx), 64'(tx_cycles), 64'(e.tx));
    chk($sformatf("v%0d_tx_seen", idx), 64'(tx_k), 64'(e.tx));
    chk($sformatf("v%0d_rx_cycles", idx), 64'(rx_cycles), 64'(e.rx));
    chk($sformatf("v%0d_turn", idx), 64'(turn_k), 64'(e.turn));
    chk($sformatf("v%0d_done_pulses", idx), 64'(dn_k), 64'(e.dn));
    chk($sformatf("v%0d_timeout", idx), 64'(timeout), 64'(e.to));
    chk($sformatf("v%0d_aborted", idx), 64'(aborted), 64'(e.ab));
    chk($sformatf("v%0d_send_len", idx), 64'(send_len), 64'(e.len));
    chk($sformatf("v%0d_oframe", idx), 64'(oFrameNumMax), 64'(e.ofm));
    chk($sformatf("v%0d_shape", idx), 64'(shape_err), 64'd0);
    chk($sformatf("v%0d_idle_outs", idx), {59'd0, busy, done, oen == {NCH{1'b0}}, 2'b00}, 64'b00100);
    tick();
  endtask

  initial begin
    int dn_k;
    //          len     ofm   to     skip  tx  rx  ab  st2   etx erx turn dn  to    ab
    vecs[0] = '{32'd16, 32'd8, 32'd0, 1'b0, 10, 20, 0, 1'b0, 10, 20, 4,  1, 1'b0, 1'b0};
    vecs[1] = '{32'd3,  32'd5, 32'd8, 1'b0, 2,  0,  0, 1'b0, 2,  8,  4,  1, 1'b1, 1'b0};
    vecs[2] = '{32'd3,  32'd5, 32'd8, 1'b0, 2,  8,  0, 1'b0, 2,  8,  4,  1, 1'b0, 1'b0};
    vecs[3] = '{32'd7,  32'd9, 32'd0, 1'b0, 1,  0,  3, 1'b0, 1,  3,  4,  0, 1'b0, 1'b1};
    vecs[4] = '{32'd40, 32'd2, 32'd6, 1'b1, 5,  0,  0, 1'b1, 5,  0,  0,  1, 1'b0, 1'b0};
    vecs[5] = '{32'd1,  32'd1, 32'd8, 1'b0, 3,  3,  0, 1'b0, 3,  3,  4,  1, 1'b0, 1'b0};

    idle_inputs();
    cfg_send_len = 32'd0; cfg_oframe_max = 32'd0; cfg_rx_timeout = 32'd0; cfg_skip_rx = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("reset_state", {state, oen, busy, done, timeout, aborted}, 64'd0);
    chk("reset_counts", {tx_cycles, rx_cycles}, 64'd0);
    chk("reset_latches", {send_len, oFrameNumMax}, 64'd0);

    // Abort while idle must not set the sticky flag.
    abort = 1'b1; tick(); abort = 1'b0;
    chk("idle_abort", {61'd0, state}, 64'(aborted));
    chk("idle_abort_flag", 64'(aborted), 64'd0);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // tx_done coinciding with the accepted start must be ignored.
    cfg_skip_rx = 1'b1; cfg_rx_timeout = 32'd0;
    start = 1'b1; tx_done = 1'b1; tick(); idle_inputs();
    chk("start_txdone_state", 64'(state), 64'd1);
    tick();
    chk("start_txdone_still_tx", 64'(state), 64'd1);
    abort = 1'b1; tick(); idle_inputs();
    chk("abort_tx", {aborted, oen, state}, {1'b1, {NCH{1'b0}}, 3'd0});

    // Reset during RX clears everything and leaves no done pulse behind.
    cfg_skip_rx = 1'b0; cfg_send_len = 32'd55; cfg_oframe_max = 32'd66;
    start = 1'b1; tick(); idle_inputs();
    tx_done = 1'b1; tick(); idle_inputs();
    for (int i = 0; i < 6; i++) tick();
    chk("pre_reset_rx", 64'(state), 64'd3);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_rx_outs", {state, oen, busy, done, timeout, aborted}, 64'd0);
    chk("rst_rx_regs", {tx_cycles, rx_cycles, send_len, oFrameNumMax}, 128'd0);
    dn_k = 0;
    for (int i = 0; i < 6; i++) begin
      if (done || busy) dn_k++;
      tick();
    end
    chk("rst_rx_no_done", 64'(dn_k), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
